// File: rtl/sobel_filter.sv
// Streaming Sobel edge detector: RGB groups of 16 pixels (R, G, B beats)
// are converted to grayscale, buffered over three rows, and emitted as
// 16 saturated gradient magnitudes per group in raster order.
module sobel_filter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         valid_in,
    output logic [127:0] data_out,
    output logic         valid_out
);

    localparam int DATA_W = 8;
    localparam int GROUPS = IMG_WIDTH / 16;
    localparam int COL_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int FL_W   = $clog2(GROUPS + 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(GROUPS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        BEAT_R = 2'd0,
        BEAT_G = 2'd1,
        BEAT_B = 2'd2
    } beat_t;

    // Weighted luma, truncated (no rounding).
    function automatic logic [DATA_W-1:0] to_gray(input logic [7:0] r,
                                                   input logic [7:0] g,
                                                   input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'd77 * 16'(r) + 16'd150 * 16'(g) + 16'd29 * 16'(b);
        return 8'(acc >> 8);
    endfunction

    // |gx| + |gy| clipped to the 8-bit pixel range.
    function automatic logic [DATA_W-1:0] sat_mag(input logic signed [10:0] gx,
                                                  input logic signed [10:0] gy);
        logic [10:0] ax;
        logic [10:0] ay;
        logic [11:0] sum;
        ax  = gx[10] ? $unsigned(-gx) : $unsigned(gx);
        ay  = gy[10] ? $unsigned(-gy) : $unsigned(gy);
        sum = 12'(ax) + 12'(ay);
        return (sum > 12'd255) ? 8'hFF : sum[7:0];
    endfunction

    // One output pixel from three 3-pixel slices (byte 0 = left column).
    function automatic logic [DATA_W-1:0] sobel_px(input logic [23:0] t,
                                                   input logic [23:0] m,
                                                   input logic [23:0] b);
        logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg;
        logic signed [10:0] gx, gy;
        gx_pos = 11'(t[23:16]) + 11'({m[23:16], 1'b0}) + 11'(b[23:16]);
        gx_neg = 11'(t[7:0])   + 11'({m[7:0],   1'b0}) + 11'(b[7:0]);
        gy_pos = 11'(b[7:0])   + 11'({b[15:8],  1'b0}) + 11'(b[23:16]);
        gy_neg = 11'(t[7:0])   + 11'({t[15:8],  1'b0}) + 11'(t[23:16]);
        gx = $signed(gx_pos - gx_neg);
        gy = $signed(gy_pos - gy_neg);
        return sat_mag(gx, gy);
    endfunction

    // 16 magnitudes from 18-pixel rows (left neighbour, group, right neighbour);
    // border pixels are forced to zero.
    function automatic logic [127:0] sobel_group(input logic [143:0] top,
                                                 input logic [143:0] mid,
                                                 input logic [143:0] bot,
                                                 input logic zero_left,
                                                 input logic zero_right,
                                                 input logic zero_all);
        logic [127:0]      res;
        logic [DATA_W-1:0] px;
        res = '0;
        for (int j = 0; j < 16; j++) begin
            px = sobel_px(top[8*j +: 24], mid[8*j +: 24], bot[8*j +: 24]);
            if (zero_all || (j == 0 && zero_left) || (j == 15 && zero_right))
                px = '0;
            res[8*j +: 8] = px;
        end
        return res;
    endfunction

    beat_t            beat;
    logic [ROW_W-1:0] row_cnt;
    logic [COL_W-1:0] col_cnt;
    logic             b_beat;
    logic [127:0]     r_hold, g_hold, gray_grp;

    logic [127:0] line1 [GROUPS];
    logic [127:0] line2 [GROUPS];

    logic [127:0] top_p0, mid_p0, bot_p0;
    logic         vld_p0, emit_p0, extra_p0, first_p0, toprow_p0, eof_p0;

    logic [127:0]      win_top, win_mid, win_bot;
    logic [DATA_W-1:0] lt, lm, lb;
    logic [DATA_W-1:0] rt, rm, rb;
    logic [127:0]      mag_comb;

    logic [127:0]  mag_p1;
    logic          vld_p1, extra_pend, extra_top, extra_eof;
    logic [FL_W-1:0] flush_left;

    assign b_beat = valid_in && (beat == BEAT_B);

    // Beat sequencer and row/group position of the incoming group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat    <= BEAT_R;
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (valid_in) begin
            case (beat)
                BEAT_R:  beat <= BEAT_G;
                BEAT_G:  beat <= BEAT_B;
                default: begin
                    beat <= BEAT_R;
                    if (col_cnt == LAST_COL) begin
                        col_cnt <= '0;
                        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Hold the R and G planes until the B plane completes the group.
    always_ff @(posedge clk) begin
        if (valid_in && beat == BEAT_R) r_hold <= data_in;
        if (valid_in && beat == BEAT_G) g_hold <= data_in;
    end

    // Grayscale of the group being completed by the current B beat.
    always_comb begin
        gray_grp = '0;
        for (int j = 0; j < 16; j++)
            gray_grp[8*j +: 8] = to_gray(r_hold[8*j +: 8], g_hold[8*j +: 8],
                                         data_in[8*j +: 8]);
    end

    // ---- stage p0: capture the new column and rotate the row buffers ----
    // Row buffers and the freshly completed three-row column.
    always_ff @(posedge clk) begin
        if (b_beat) begin
            line2[col_cnt] <= line1[col_cnt];
            line1[col_cnt] <= gray_grp;
            top_p0         <= line2[col_cnt];
            mid_p0         <= line1[col_cnt];
            bot_p0         <= gray_grp;
        end
    end

    // Emission decisions for the column captured at p0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0    <= 1'b0;
            emit_p0   <= 1'b0;
            extra_p0  <= 1'b0;
            first_p0  <= 1'b0;
            toprow_p0 <= 1'b0;
            eof_p0    <= 1'b0;
        end else begin
            vld_p0    <= b_beat;
            emit_p0   <= b_beat && (row_cnt != '0) && (col_cnt != '0);
            extra_p0  <= b_beat && (row_cnt != '0) && (col_cnt == LAST_COL);
            first_p0  <= (col_cnt == COL_W'(1));
            toprow_p0 <= (row_cnt == ROW_W'(1));
            eof_p0    <= (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);
        end
    end

    // Sliding window: group to be emitted plus the left neighbour column.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            lt      <= win_top[127:120];
            lm      <= win_mid[127:120];
            lb      <= win_bot[127:120];
            win_top <= top_p0;
            win_mid <= mid_p0;
            win_bot <= bot_p0;
        end
    end

    // Gradient of the windowed group; the extra end-of-row beat has no right neighbour.
    always_comb begin
        rt       = emit_p0 ? top_p0[7:0] : 8'd0;
        rm       = emit_p0 ? mid_p0[7:0] : 8'd0;
        rb       = emit_p0 ? bot_p0[7:0] : 8'd0;
        mag_comb = sobel_group({rt, win_top, lt}, {rm, win_mid, lm}, {rb, win_bot, lb},
                               emit_p0 && first_p0, !emit_p0,
                               emit_p0 ? toprow_p0 : extra_top);
    end

    // ---- stage p1: register magnitudes ----
    // Magnitude register.
    always_ff @(posedge clk) begin
        if (emit_p0 || extra_pend) mag_p1 <= mag_comb;
    end

    // p1 valid and the pending last-group beat of a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            extra_pend <= 1'b0;
            extra_top  <= 1'b0;
            extra_eof  <= 1'b0;
        end else begin
            vld_p1     <= emit_p0 || extra_pend;
            extra_pend <= extra_p0;
            if (extra_p0) begin
                extra_top <= toprow_p0;
                extra_eof <= eof_p0;
            end
        end
    end

    // ---- output stage: computed beats, then the bottom-row zero flush ----
    // Output register and flush counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            flush_left <= '0;
        end else begin
            valid_out <= vld_p1 || (flush_left != '0);
            if (vld_p1)
                data_out <= mag_p1;
            else if (flush_left != '0)
                data_out <= '0;
            if (extra_pend && extra_eof)
                flush_left <= FL_W'(GROUPS);
            else if (!vld_p1 && flush_left != '0)
                flush_left <= flush_left - 1'b1;
        end
    end

endmodule

// File: tb/tb_sobel_filter.sv
// Bench for sobel_filter: table of image patterns with hand-derived spot
// values, random frames against a whole-image reference model, and reset cases.
module tb_sobel_filter;

    localparam int W = 32;
    localparam int H = 4;
    localparam int G = W / 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] data_in = '0;
    logic         valid_in = 1'b0;
    logic [127:0] data_out;
    logic         valid_out;

    sobel_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           img [3][H][W];
    logic [127:0] exp_data[$];
    logic [127:0] act_data[$];
    int           exp_time[$];
    int           act_time[$];
    int           n_checks = 0;
    int           n_pass = 0;

    typedef struct {
        int          kind;   // 0 uniform, 1 vertical step at x=16, 2 horizontal step at y=2
        logic [23:0] ca;     // {R,G,B} before the step
        logic [23:0] cb;     // {R,G,B} after the step
        int          sy;
        int          sx;
        int          sval;
    } vec_t;

    always @(negedge clk) begin
        if (valid_out) begin
            act_data.push_back(data_out);
            act_time.push_back(cyc);
        end
    end

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill(input int kind, input logic [23:0] ca, input logic [23:0] cb);
        logic [23:0] col;
        for (int p = 0; p < 3; p++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    if (kind == 3) img[p][y][x] = $urandom_range(0, 255);
                    else begin
                        col = ((kind == 1 && x >= 16) || (kind == 2 && y >= 2)) ? cb : ca;
                        img[p][y][x] = int'(col[23-8*p -: 8]);
                    end
                end
    endtask

    // Reference: whole-frame grayscale then textbook 3x3 Sobel, borders zero.
    task automatic push_expected_frame();
        int gr [H][W];
        int gx, gy, v, x;
        logic [127:0] beat;
        for (int y = 0; y < H; y++)
            for (int xx = 0; xx < W; xx++)
                gr[y][xx] = (77 * img[0][y][xx] + 150 * img[1][y][xx] + 29 * img[2][y][xx]) / 256;
        for (int y = 0; y < H; y++)
            for (int gi = 0; gi < G; gi++) begin
                beat = '0;
                for (int j = 0; j < 16; j++) begin
                    x = gi * 16 + j;
                    v = 0;
                    if (y > 0 && y < H - 1 && x > 0 && x < W - 1) begin
                        gx = (gr[y-1][x+1] + 2 * gr[y][x+1] + gr[y+1][x+1])
                           - (gr[y-1][x-1] + 2 * gr[y][x-1] + gr[y+1][x-1]);
                        gy = (gr[y+1][x-1] + 2 * gr[y+1][x] + gr[y+1][x+1])
                           - (gr[y-1][x-1] + 2 * gr[y-1][x] + gr[y-1][x+1]);
                        v = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                        if (v > 255) v = 255;
                    end
                    beat[8*j +: 8] = 8'(v);
                end
                exp_data.push_back(beat);
            end
    endtask

    // Drives groups in raster order from the image; records when outputs are due.
    task automatic send_frame(input int ngroups, input bit gaps);
        int r, c, k, n;
        logic [127:0] tmp;
        for (int g = 0; g < ngroups; g++) begin
            r = (g / G) % H;
            c = g % G;
            for (int p = 0; p < 3; p++) begin
                if (gaps) begin
                    n = $urandom_range(0, 2);
                    repeat (n) begin
                        @(negedge clk);
                        valid_in = 1'b0;
                        data_in  = rand128();
                    end
                end
                @(negedge clk);
                for (int j = 0; j < 16; j++) tmp[8*j +: 8] = 8'(img[p][r][c*16+j]);
                data_in  = tmp;
                valid_in = 1'b1;
                if (p == 2) begin
                    k = cyc + 1;
                    if (r >= 1 && c >= 1) exp_time.push_back(k + 2);
                    if (r >= 1 && c == G - 1) exp_time.push_back(k + 3);
                    if (r == H - 1 && c == G - 1)
                        for (int f = 0; f < G; f++) exp_time.push_back(k + 4 + f);
                end
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = rand128();
    endtask

    task automatic drain();
        repeat (3 * G + 12) @(negedge clk);
    endtask

    task automatic verify(input string tag);
        check(act_time.size() == exp_time.size(), {tag, "_beat_count"},
              128'(act_time.size()), 128'(exp_time.size()));
        for (int i = 0; i < act_time.size(); i++) begin
            if (i < exp_time.size())
                check(act_time[i] == exp_time[i], {tag, "_time"},
                      128'(act_time[i]), 128'(exp_time[i]));
            if (i < exp_data.size())
                check(act_data[i] == exp_data[i], {tag, "_data"}, act_data[i], exp_data[i]);
        end
        exp_data.delete();
        exp_time.delete();
        act_data.delete();
        act_time.delete();
    endtask

    vec_t vecs[12];

    initial begin
        logic [127:0] b;
        int idx;

        vecs[0]  = '{0, {8'd100, 8'd100, 8'd100}, 24'h0,     1, 5,  0};
        vecs[1]  = '{1, 24'h000000,               24'hFFFFFF, 1, 15, 255};
        vecs[2]  = '{1, 24'h000000,               24'hFFFFFF, 2, 16, 255};
        vecs[3]  = '{1, 24'h000000,               24'hFFFFFF, 1, 14, 0};
        vecs[4]  = '{1, 24'h000000,               24'hFFFFFF, 3, 15, 0};
        vecs[5]  = '{2, {8'd10, 8'd10, 8'd10},    {8'd20, 8'd20, 8'd20}, 1, 5,  40};
        vecs[6]  = '{2, {8'd10, 8'd10, 8'd10},    {8'd20, 8'd20, 8'd20}, 2, 30, 40};
        vecs[7]  = '{2, {8'd10, 8'd10, 8'd10},    {8'd20, 8'd20, 8'd20}, 2, 31, 0};
        vecs[8]  = '{0, 24'hFF0000,               24'h0,     1, 7,  0};
        vecs[9]  = '{0, 24'h00FF00,               24'h0,     2, 20, 0};
        vecs[10] = '{1, 24'h000000,               24'hFF0000, 1, 16, 255};
        vecs[11] = '{1, 24'h000000,               24'hFF0000, 1, 17, 0};

        // Held in reset with activity on the input: outputs stay zero.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid_in = 1'($urandom_range(0, 1));
            data_in  = rand128();
            #1;
            check(valid_out == 1'b0 && data_out == '0, "reset_hold",
                  {data_out[126:0], valid_out}, 128'h0);
        end
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b1;

        // Pattern table.
        for (int i = 0; i < 12; i++) begin
            fill(vecs[i].kind, vecs[i].ca, vecs[i].cb);
            push_expected_frame();
            send_frame(H * G, (i % 2) == 1);
            drain();
            check(act_data.size() == H * G, "frame_beats", 128'(act_data.size()), 128'(H * G));
            idx = vecs[i].sy * G + vecs[i].sx / 16;
            if (idx < act_data.size()) begin
                b = act_data[idx];
                check(b[8*(vecs[i].sx % 16) +: 8] == 8'(vecs[i].sval), "spot",
                      128'(b[8*(vecs[i].sx % 16) +: 8]), 128'(vecs[i].sval));
            end else begin
                check(1'b0, "spot_missing", 128'(act_data.size()), 128'(idx + 1));
            end
            verify("table");
        end

        // Random frames back to back, the next starting during the flush.
        for (int f = 0; f < 4; f++) begin
            fill(3, '0, '0);
            push_expected_frame();
            send_frame(H * G, f >= 2);
        end
        drain();
        verify("random");

        // Reset in the middle of a row, after R and G of the next group.
        fill(3, '0, '0);
        send_frame(3, 1'b1);
        @(negedge clk); valid_in = 1'b1; data_in = rand128();
        @(negedge clk); valid_in = 1'b1; data_in = rand128();
        @(negedge clk); valid_in = 1'b0;
        #2 rst = 1'b0;
        #1 check(valid_out == 1'b0 && data_out == '0, "reset_mid_row",
                 {data_out[126:0], valid_out}, 128'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        verify("pre_reset");
        fill(3, '0, '0);
        push_expected_frame();
        send_frame(H * G, 1'b1);
        drain();
        verify("after_reset");

        // Reset while a row's output pair is in flight.
        fill(3, '0, '0);
        push_expected_frame();
        send_frame(G + 2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check(valid_out == 1'b0 && data_out == '0, "reset_in_flight",
                 {data_out[126:0], valid_out}, 128'h0);
        while (exp_time.size() > 0 && exp_time[$] > cyc) void'(exp_time.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drain();
        verify("in_flight");
        fill(1, 24'h000000, 24'hFFFFFF);
        push_expected_frame();
        send_frame(H * G, 1'b0);
        drain();
        verify("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
